// File: rtl/controlador_es.sv
// I/O sequencer for the Forth core: valid/ready handshakes on the input/output ports, PC hold via haltES.
// Optional wait-state abort is enabled by defining ES_TIMEOUT_EN.
module controlador_es #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CICLOS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            seletorES,
  input  logic [DATA_WIDTH-1:0] dado_t,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  haltES,
  output logic [DATA_WIDTH-1:0] dado_entrada,
  output logic                  es_concluido,
  output logic                  erro_es
);

  typedef enum logic [1:0] {
    OCIOSO         = 2'd0,
    ESPERA_ENTRADA = 2'd1,
    ESPERA_SAIDA   = 2'd2,
    CONCLUI        = 2'd3
  } estado_t;

  estado_t               r_estado;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0] r_dado_entrada;
  logic                  r_es_concluido;
  logic                  w_sel_le;
  logic                  w_sel_escreve;

  assign w_sel_le      = (seletorES == 2'b01);
  assign w_sel_escreve = (seletorES == 2'b10);

  // in_ready is only raised where a capture happens on the same edge, so one word per read
  assign in_ready = ((r_estado == OCIOSO) && w_sel_le) || (r_estado == ESPERA_ENTRADA);
  assign haltES   = ((r_estado == OCIOSO) && (w_sel_le || w_sel_escreve))
                  || (r_estado == ESPERA_ENTRADA) || (r_estado == ESPERA_SAIDA);

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign dado_entrada = r_dado_entrada;
  assign es_concluido = r_es_concluido;

`ifdef ES_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CICLOS - 1);

  logic [CW-1:0] r_cnt;
  logic          r_erro_es;
  logic          w_expirou;

  assign w_expirou = (r_cnt == CNT_MAX);
  assign erro_es   = r_erro_es;
`else
  assign erro_es   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado       <= OCIOSO;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_dado_entrada <= '0;
      r_es_concluido <= 1'b0;
`ifdef ES_TIMEOUT_EN
      r_cnt          <= '0;
      r_erro_es      <= 1'b0;
`endif
    end else begin
      r_es_concluido <= 1'b0;
`ifdef ES_TIMEOUT_EN
      r_erro_es      <= 1'b0;
`endif
      case (r_estado)
        OCIOSO: begin
`ifdef ES_TIMEOUT_EN
          r_cnt <= '0;
`endif
          if (w_sel_le) begin
            if (in_valid) begin
              r_dado_entrada <= in_data;
              r_es_concluido <= 1'b1;
              r_estado       <= CONCLUI;
            end else begin
              r_estado <= ESPERA_ENTRADA;
            end
          end else if (w_sel_escreve) begin
            r_out_data  <= dado_t;
            r_out_valid <= 1'b1;
            r_estado    <= ESPERA_SAIDA;
          end
        end
        ESPERA_ENTRADA: begin
          if (in_valid) begin
            r_dado_entrada <= in_data;
            r_es_concluido <= 1'b1;
            r_estado       <= CONCLUI;
          end
`ifdef ES_TIMEOUT_EN
          else if (w_expirou) begin
            r_dado_entrada <= '0;
            r_es_concluido <= 1'b1;
            r_erro_es      <= 1'b1;
            r_estado       <= CONCLUI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ESPERA_SAIDA: begin
          if (out_ready) begin
            r_out_valid    <= 1'b0;
            r_es_concluido <= 1'b1;
            r_estado       <= CONCLUI;
          end
`ifdef ES_TIMEOUT_EN
          else if (w_expirou) begin
            r_out_valid    <= 1'b0;
            r_es_concluido <= 1'b1;
            r_erro_es      <= 1'b1;
            r_estado       <= CONCLUI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        // seletorES is ignored here: the PC advances at the end of this cycle
        CONCLUI: r_estado <= OCIOSO;
        default: r_estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_es.sv
// Bench for controlador_es: vector table of I/O instructions with a retirement scoreboard, plus reset/timeout sequences.
module tb_controlador_es;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  seletorES;
  logic [15:0] dado_t, in_data, out_data, dado_entrada;
  logic        in_valid, in_ready, out_valid, out_ready, haltES, es_concluido, erro_es;

  controlador_es #(.DATA_WIDTH(16), .TIMEOUT_CICLOS(8)) dut (
    .clk(clk), .rst_n(rst_n), .seletorES(seletorES), .dado_t(dado_t),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .haltES(haltES), .dado_entrada(dado_entrada),
    .es_concluido(es_concluido), .erro_es(erro_es)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] din;
    logic [15:0] dt;
    int          go;     // cycle index from which in_valid/out_ready is asserted
    logic        halt0;
    logic        rdy0;
    int          ncyc;   // cycle of es_concluido (0 = never)
    logic        err;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [15:0] d;
    logic        err;
  } sb_t;

  sb_t sbq[$];
  sb_t e_mon;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
    end
  endtask

  // Retirement scoreboard
  always @(negedge clk) begin
    if (rst_n && es_concluido) begin
      if (sbq.size() == 0) chk("es_concluido_inesperado", 32'd1, 32'd0);
      else begin
        e_mon = sbq.pop_front();
        if (e_mon.wr) begin
          chk("out_data_fim", {16'h0, out_data}, {16'h0, e_mon.d});
          chk("out_valid_fim", {31'h0, out_valid}, 32'd0);
        end else begin
          chk("dado_entrada", {16'h0, dado_entrada}, {16'h0, e_mon.d});
        end
        chk("erro_es", {31'h0, erro_es}, {31'h0, e_mon.err});
      end
    end
  end

  task automatic do_vec(input vec_t v);
    int   cyc, nhalt, nov, nrdy;
    logic seen;
    sb_t  e;
    @(posedge clk); #1;
    seletorES = v.sel; dado_t = v.dt; in_data = v.din;
    in_valid  = (v.sel == 2'b01) && (v.go == 0);
    out_ready = 1'b0;
    #1;
    chk("halt_ciclo0", {31'h0, haltES}, {31'h0, v.halt0});
    chk("in_ready_ciclo0", {31'h0, in_ready}, {31'h0, v.rdy0});
    if (v.sel == 2'b01 || v.sel == 2'b10) begin
      e.wr  = (v.sel == 2'b10);
      e.d   = (v.sel == 2'b10) ? v.dt : (v.err ? 16'h0 : v.din);
      e.err = v.err;
      sbq.push_back(e);
    end
    nhalt = int'(haltES); nov = 0; nrdy = int'(in_ready); seen = 1'b0; cyc = 0;
    while (!seen && cyc < ((v.ncyc == 0) ? 10 : 40)) begin
      @(posedge clk); #1;
      cyc++;
      seletorES = (v.ncyc == 0) ? v.sel : 2'b00;
      in_valid  = (v.sel == 2'b01) && (cyc >= v.go);
      out_ready = (v.sel == 2'b10) && (cyc >= v.go);
      #1;
      if (es_concluido) begin
        seen = 1'b1;
        chk("halt_em_conclui", {31'h0, haltES}, 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
      end else begin
        nhalt += int'(haltES);
        nov   += int'(out_valid);
        nrdy  += int'(in_ready);
        if (out_valid) chk("out_data_estavel", {16'h0, out_data}, {16'h0, v.dt});
      end
    end
    chk("concluiu", {31'h0, seen}, (v.ncyc != 0) ? 32'd1 : 32'd0);
    if (seen) chk("latencia", cyc, v.ncyc);
    chk("ciclos_halt", nhalt, v.ncyc);
    chk("ciclos_out_valid", nov, (v.sel == 2'b10) ? v.ncyc - 1 : 0);
    if (v.ncyc == 0) chk("ciclos_in_ready_noop", nrdy, 0);
    seletorES = 2'b00;
  endtask

  vec_t tab[8];

  initial begin
    tab[0] = '{2'b01, 16'h00A5, 16'h0000, 0,  1'b1, 1'b1, 1, 1'b0};
    tab[1] = '{2'b01, 16'h1234, 16'h0000, 5,  1'b1, 1'b1, 6, 1'b0};
    tab[2] = '{2'b10, 16'h0000, 16'hBEEF, 4,  1'b1, 1'b0, 5, 1'b0};
    tab[3] = '{2'b11, 16'h7777, 16'h8888, 99, 1'b0, 1'b0, 0, 1'b0};
    tab[4] = '{2'b00, 16'h7777, 16'h8888, 99, 1'b0, 1'b0, 0, 1'b0};
    tab[5] = '{2'b10, 16'h0000, 16'h5A5A, 1,  1'b1, 1'b0, 2, 1'b0};
    tab[6] = '{2'b01, 16'hFFFF, 16'h0000, 1,  1'b1, 1'b1, 2, 1'b0};
    tab[7] = '{2'b10, 16'h0000, 16'h0001, 2,  1'b1, 1'b0, 3, 1'b0};

    rst_n = 1'b0; seletorES = 2'b00; dado_t = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_data", {16'h0, out_data}, 32'd0);
    chk("rst_dado_entrada", {16'h0, dado_entrada}, 32'd0);
    chk("rst_es_concluido", {31'h0, es_concluido}, 32'd0);
    chk("rst_erro_es", {31'h0, erro_es}, 32'd0);
    chk("rst_halt", {31'h0, haltES}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tab[i]) do_vec(tab[i]);

    // Reset while a write is waiting for out_ready
    @(posedge clk); #1;
    seletorES = 2'b10; dado_t = 16'hCAFE; out_ready = 1'b0;
    @(posedge clk); #1;
    seletorES = 2'b00;
    @(posedge clk); #1;
    chk("espera_saida_valid", {31'h0, out_valid}, 32'd1);
    chk("espera_saida_halt", {31'h0, haltES}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_async_halt", {31'h0, haltES}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 seletorES = 2'b01;
    #1;
    chk("pos_rst_halt_le", {31'h0, haltES}, 32'd1);
    chk("pos_rst_in_ready", {31'h0, in_ready}, 32'd1);
    seletorES = 2'b00;
    #1;
    chk("pos_rst_halt_ocioso", {31'h0, haltES}, 32'd0);
    do_vec('{2'b01, 16'h0F0F, 16'h0000, 0, 1'b1, 1'b1, 1, 1'b0});

`ifdef ES_TIMEOUT_EN
    do_vec('{2'b01, 16'h9999, 16'h0000, 99, 1'b1, 1'b1, 9, 1'b1});
    do_vec('{2'b01, 16'hC0DE, 16'h0000, 8,  1'b1, 1'b1, 9, 1'b0});
    do_vec('{2'b10, 16'h0000, 16'hD00D, 99, 1'b1, 1'b0, 9, 1'b1});
    do_vec('{2'b10, 16'h0000, 16'hFACE, 8,  1'b1, 1'b0, 9, 1'b0});
`endif

    @(posedge clk); #1;
    chk("fila_vazia", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
